// File: rtl/io_map_pkg.sv
// Address map and field widths shared by the I/O peripheral controller.
package io_map_pkg;
  localparam logic [31:0] ADDR_SW        = 32'h1;
  localparam logic [31:0] ADDR_BTN_LEVEL = 32'h2;
  localparam logic [31:0] ADDR_BTN_EVENT = 32'h3;
  localparam logic [31:0] ADDR_LED       = 32'h4;

  localparam int SW_W  = 16;
  localparam int BTN_W = 5;
  localparam int LED_W = 16;
endpackage

// File: rtl/btn_debounce.sv
// One push button: input synchroniser, stability counter, debounced level and
// a single-cycle rise pulse aligned with the level's 0->1 update.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    // The counter only runs while the input disagrees with the level, and is
    // cleared on acceptance, so it can never reach its wrap point.
    if (btn_sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = btn_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/io_periph_ctrl.sv
// Memory-mapped switch/button/LED controller for the Risc32 I/O port with
// registered one-cycle read responses.
module io_periph_ctrl
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  output logic [31:0] io_read_value,
  output logic        io_read_valid,
  input  logic [15:0] SW,
  input  logic [4:0]  BTN,
  output logic [15:0] LED
);

  logic [SW_W-1:0]  sw_sync_q [SYNC_STAGES];
  logic [SW_W-1:0]  sw_sync_d [SYNC_STAGES];
  logic [BTN_W-1:0] btn_level, btn_rise;
  logic [BTN_W-1:0] evt_q, evt_d, evt_clr;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^io_write_value[31:LED_W];

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(BTN[g]),
      .level  (btn_level[g]),
      .rise   (btn_rise[g])
    );
  end

  always_comb begin
    sw_sync_d[0] = SW;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
  end

  always_comb begin
    led_d    = led_q;
    rdata_d  = rdata_q;
    rvalid_d = io_read_en;
    evt_clr  = '0;

    if (io_write_en && io_address == ADDR_LED) begin
      led_d = io_write_value[LED_W-1:0];
    end
    if (io_read_en && io_address == ADDR_BTN_EVENT) begin
      evt_clr = '1;
    end
    if (io_write_en && io_address == ADDR_BTN_EVENT) begin
      evt_clr = evt_clr | io_write_value[BTN_W-1:0];
    end
    // A new press in the same cycle as a clear must not be lost.
    evt_d = (evt_q & ~evt_clr) | btn_rise;

    // Read mux samples pre-write state so a same-cycle write is not visible.
    if (io_read_en) begin
      case (io_address)
        ADDR_SW:        rdata_d = {{(32-SW_W){1'b0}}, sw_sync_q[SYNC_STAGES-1]};
        ADDR_BTN_LEVEL: rdata_d = {{(32-BTN_W){1'b0}}, btn_level};
        ADDR_BTN_EVENT: rdata_d = {{(32-BTN_W){1'b0}}, evt_q};
        ADDR_LED:       rdata_d = {{(32-LED_W){1'b0}}, led_q};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
      evt_q    <= '0;
      led_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_d[i];
      end
      evt_q    <= evt_d;
      led_q    <= led_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign io_read_value = rdata_q;
  assign io_read_valid = rvalid_q;
  assign LED           = led_q;

endmodule

// File: tb/tb_io_periph_ctrl.sv
// Bench for io_periph_ctrl: directed scenarios plus random traffic checked
// against a register-level reference model.
module tb_io_periph_ctrl;

  localparam int DB   = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io_address = '0;
  logic [31:0] io_write_value = '0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [31:0] io_read_value;
  logic        io_read_valid;
  logic [15:0] SW = '0;
  logic [4:0]  BTN = '0;
  logic [15:0] LED;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_periph_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (20),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_address    (io_address),
    .io_write_value(io_write_value),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_read_value (io_read_value),
    .io_read_valid (io_read_valid),
    .SW            (SW),
    .BTN           (BTN),
    .LED           (LED)
  );

  // Reference model: what the core should observe, derived from the
  // register map rules. Raw inputs reach the logic SYNC edges late; a button
  // level flips after DB consecutive disagreeing samples.
  logic [15:0] m_sw_h [SYNC];
  logic [4:0]  m_btn_h [SYNC];
  logic [4:0]  m_lvl, m_evt;
  int          m_run [5];
  logic [15:0] m_led;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  logic [4:0]  n_lvl, n_rise, n_clr, n_evt;
  int          n_run [5];
  logic [15:0] n_led;
  logic [31:0] n_rdata;

  always_comb begin
    n_lvl  = m_lvl;
    n_rise = '0;
    for (int i = 0; i < 5; i++) begin
      n_run[i] = 0;
      if (m_btn_h[SYNC-1][i] != m_lvl[i]) begin
        if (m_run[i] + 1 >= DB) begin
          n_lvl[i]  = m_btn_h[SYNC-1][i];
          n_rise[i] = m_btn_h[SYNC-1][i];
        end else begin
          n_run[i] = m_run[i] + 1;
        end
      end
    end
    n_clr = '0;
    if (io_read_en && io_address == 32'h3)  n_clr = 5'h1F;
    if (io_write_en && io_address == 32'h3) n_clr = n_clr | io_write_value[4:0];
    n_evt = (m_evt & ~n_clr) | n_rise;
    n_led = (io_write_en && io_address == 32'h4) ? io_write_value[15:0] : m_led;
    n_rdata = m_rdata;
    if (io_read_en) begin
      case (io_address)
        32'h1:   n_rdata = {16'h0, m_sw_h[SYNC-1]};
        32'h2:   n_rdata = {27'h0, m_lvl};
        32'h3:   n_rdata = {27'h0, m_evt};
        32'h4:   n_rdata = {16'h0, m_led};
        default: n_rdata = 32'h0;
      endcase
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) begin
        m_sw_h[i]  <= '0;
        m_btn_h[i] <= '0;
      end
      for (int i = 0; i < 5; i++) m_run[i] <= 0;
      m_lvl <= '0; m_evt <= '0; m_led <= '0; m_rdata <= '0; m_rvalid <= 1'b0;
    end else begin
      m_sw_h[0]  <= SW;
      m_btn_h[0] <= BTN;
      for (int i = 1; i < SYNC; i++) begin
        m_sw_h[i]  <= m_sw_h[i-1];
        m_btn_h[i] <= m_btn_h[i-1];
      end
      for (int i = 0; i < 5; i++) m_run[i] <= n_run[i];
      m_lvl <= n_lvl; m_evt <= n_evt; m_led <= n_led;
      m_rdata <= n_rdata; m_rvalid <= io_read_en;
    end
  end

  // Called at a falling edge; returns at the next falling edge, where the
  // response to this access is visible.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd);
    io_read_en = rd; io_write_en = wr; io_address = a; io_write_value = wd;
    @(negedge clk);
    io_read_en = 1'b0; io_write_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (LED !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0000", LED); end
    checks++; if (io_read_value !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", io_read_value); end
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", io_read_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b want 0", io_read_valid); end
    issue(1'b1, 1'b0, 32'h4, 32'h0);
    checks++; if (io_read_valid !== 1'b1 || io_read_value !== 32'h0) begin
      errors++; $display("FAIL reset_led_read: got v=%b %h want v=1 0", io_read_valid, io_read_value); end
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b want 0", io_read_valid); end
  endtask

  task automatic test_led;
    issue(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
    checks++; if (LED !== 16'hBEEF) begin errors++; $display("FAIL led_write: got %h want beef", LED); end
    issue(1'b1, 1'b0, 32'h4, 32'h0);
    checks++; if (io_read_valid !== 1'b1 || io_read_value !== 32'h0000BEEF) begin
      errors++; $display("FAIL led_read: got v=%b %h want v=1 0000beef", io_read_valid, io_read_value); end
    issue(1'b0, 1'b1, 32'h5, 32'hFFFF);
    checks++; if (LED !== 16'hBEEF || io_read_value !== 32'h0000BEEF) begin
      errors++; $display("FAIL bad_addr_write: got led=%h rd=%h want beef 0000beef", LED, io_read_value); end
    issue(1'b1, 1'b0, 32'h7, 32'h0);
    checks++; if (io_read_valid !== 1'b1 || io_read_value !== 32'h0) begin
      errors++; $display("FAIL bad_addr_read: got v=%b %h want v=1 0", io_read_valid, io_read_value); end
    // Same-cycle read and write: read returns the old LED value.
    issue(1'b1, 1'b1, 32'h4, 32'h00001234);
    checks++; if (io_read_value !== 32'h0000BEEF || LED !== 16'h1234) begin
      errors++; $display("FAIL led_rw_same: got rd=%h led=%h want 0000beef 1234", io_read_value, LED); end
  endtask

  task automatic test_switch;
    SW = 16'hA5C3;
    repeat (3) @(negedge clk);
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL sw_pre_valid: got %b want 0", io_read_valid); end
    issue(1'b1, 1'b0, 32'h1, 32'h0);
    checks++; if (io_read_valid !== 1'b1 || io_read_value !== 32'h0000A5C3) begin
      errors++; $display("FAIL sw_read: got v=%b %h want v=1 0000a5c3", io_read_valid, io_read_value); end
  endtask

  task automatic test_debounce;
    int first;
    BTN = 5'b00100; @(negedge clk);
    BTN = 5'b00000; @(negedge clk);
    BTN = 5'b00100; @(negedge clk);
    BTN = 5'b00000;
    repeat (8) @(negedge clk);
    issue(1'b1, 1'b0, 32'h2, 32'h0);
    checks++; if (io_read_value !== 32'h0) begin errors++; $display("FAIL bounce_level: got %h want 0", io_read_value); end
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h0) begin errors++; $display("FAIL bounce_event: got %h want 0", io_read_value); end
    BTN = 5'b00100;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 1'b0, 32'h2, 32'h0);
      checks++; if (io_read_value !== m_rdata) begin
        errors++; $display("FAIL level_poll[%0d]: got %h want %h", i, io_read_value, m_rdata); end
      if (first < 0 && io_read_value == 32'h4) first = i;
    end
    checks++; if (first != SYNC + DB) begin errors++; $display("FAIL level_latency: got %0d want %0d", first, SYNC + DB); end
  endtask

  task automatic test_events;
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h4) begin errors++; $display("FAIL evt_read1: got %h want 4", io_read_value); end
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h0) begin errors++; $display("FAIL evt_read2: got %h want 0", io_read_value); end
    BTN = 5'b00101;
    repeat (10) @(negedge clk);
    issue(1'b0, 1'b1, 32'h3, 32'h1);
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h0 || m_rdata !== 32'h0) begin
      errors++; $display("FAIL evt_w1c: got %h want 0", io_read_value); end
    // Rise of BTN[4] lands on the edge that also services the clearing read.
    BTN = 5'b10101;
    repeat (SYNC + DB - 1) @(negedge clk);
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h0) begin errors++; $display("FAIL evt_race_old: got %h want 0", io_read_value); end
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_value !== 32'h10) begin errors++; $display("FAIL evt_race_set: got %h want 10", io_read_value); end
  endtask

  task automatic test_mid_reset;
    issue(1'b0, 1'b1, 32'h4, 32'h0000C0DE);
    io_read_en = 1'b1; io_address = 32'h4;
    #2 rst_n = 1'b0;
    @(negedge clk);
    io_read_en = 1'b0;
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL reset_kills_valid: got %b want 0", io_read_valid); end
    checks++; if (LED !== 16'h0) begin errors++; $display("FAIL reset_led_mid: got %h want 0", LED); end
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'h3, 32'h0);
    checks++; if (io_read_valid !== 1'b1 || io_read_value !== 32'h0) begin
      errors++; $display("FAIL reset_events: got v=%b %h want v=1 0", io_read_valid, io_read_value); end
    checks++; if (LED !== 16'h0) begin errors++; $display("FAIL reset_led_after: got %h want 0", LED); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(9) == 0) BTN = BTN ^ (5'b1 << $urandom_range(4));
      if ($urandom_range(15) == 0) SW = 16'($urandom);
      issue(1'($urandom_range(1)), ($urandom_range(2) == 0), 32'($urandom_range(7)), $urandom);
      checks++; if (io_read_valid !== m_rvalid || io_read_value !== m_rdata || LED !== m_led) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b rd=%h led=%h want v=%b rd=%h led=%h",
                 c, io_read_valid, io_read_value, LED, m_rvalid, m_rdata, m_led);
      end
    end
  endtask

  task automatic test_back_to_back;
    BTN = 5'b0; SW = 16'h3C5A;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, (i % 3 == 0), 32'(i % 5), 32'(i * 32'h1111));
      checks++; if (io_read_valid !== 1'b1 || io_read_value !== m_rdata || LED !== m_led) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b rd=%h led=%h want v=1 rd=%h led=%h",
                 i, io_read_valid, io_read_value, LED, m_rdata, m_led);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_led();
    test_switch();
    test_debounce();
    test_events();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
